// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy
// scoreboard.
//
// The write-back stage writes results here. Decode reads operands from
// the NRD combinational read ports. A write presented in the same cycle
// as a read is forwarded straight to that read. Issue allocates a
// destination register, which marks it busy until its result is written.
// A flush clears every busy bit.
//
// Ports:
//   clk, reset_n     core clock, asynchronous active-low reset
//   rd_en_i          per-port read enable
//   rd_addr_i        read addresses, port k at [k*AW +: AW]
//   rd_data_o        read data (combinational), port k at [k*XLEN +: XLEN]
//   rd_busy_o        the addressed register has an outstanding producer
//   wr_en_i          write-back enables
//   wr_addr_i        write-back addresses
//   wr_data_i        write-back data
//   alloc_en_i       issue-time destination allocation (sets busy)
//   alloc_addr_i     allocated destination addresses
//   flush_i          clears all busy bits

module regfile_mp_rdport #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic                           rd_en,
    input  logic [AW-1:0]                  rd_addr,
    input  logic [NREG-1:0][XLEN-1:0]      regs,
    input  logic [NREG-1:0]                busy,
    input  logic [NWR-1:0]                 wr_vld,
    input  logic [NWR-1:0][AW-1:0]         wr_addr,
    input  logic [NWR-1:0][XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]                rd_data,
    output logic                           rd_busy
);
    logic            hit;
    logic [XLEN-1:0] byp;

    // Ascending scan, so the highest-index writer wins the forward, the
    // same as in the array update.
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_vld[j] && wr_addr[j] == rd_addr) begin
                hit = 1'b1;
                byp = wr_data[j];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (rd_en && rd_addr != '0) begin
            rd_data = hit ? byp : regs[rd_addr];
            // A forwarded result means the producer is done.
            rd_busy = busy[rd_addr] && !hit;
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 4,
    parameter int NWR  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NRD-1:0]       rd_en_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic [NWR-1:0]       wr_en_i,
    input  logic [NWR*AW-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]  wr_data_i,
    input  logic [NWR-1:0]       alloc_en_i,
    input  logic [NWR*AW-1:0]    alloc_addr_i,
    input  logic                 flush_i
);
    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;

    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic [NWR-1:0][AW-1:0]    alloc_addr;
    logic [NWR-1:0]            wr_vld;
    logic [NWR-1:0]            alloc_vld;

    assign rd_addr    = rd_addr_i;
    assign wr_addr    = wr_addr_i;
    assign wr_data    = wr_data_i;
    assign alloc_addr = alloc_addr_i;
    assign rd_data_o  = rd_data;

    // r0 is hardwired. Dropping its writes and allocations here also keeps
    // it from ever producing a bypass hit.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wr_vld[j]    = wr_en_i[j] && wr_addr[j] != '0;
            alloc_vld[j] = alloc_en_i[j] && alloc_addr[j] != '0;
        end
    end

    // Busy priority: flush > allocate > write completion > hold. Each
    // later assignment overrides the earlier ones. Write ports are scanned
    // in ascending order, so the highest index wins a collision.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_vld[j]) begin
                regs_d[wr_addr[j]] = wr_data[j];
                busy_d[wr_addr[j]] = 1'b0;
            end
        end
        for (int j = 0; j < NWR; j++) begin
            if (alloc_vld[j]) busy_d[alloc_addr[j]] = 1'b1;
        end
        if (flush_i) busy_d = '0;
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_mp_rdport #(
            .XLEN(XLEN), .NREG(NREG), .AW(AW), .NWR(NWR)
        ) u_rdport (
            .rd_en   (rd_en_i[k]),
            .rd_addr (rd_addr[k]),
            .regs    (regs_q),
            .busy    (busy_q),
            .wr_vld  (wr_vld),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[k]),
            .rd_busy (rd_busy_o[k])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    localparam int XLEN = 64, NREG = 32, AW = 5, NRD = 4, NWR = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NRD-1:0]      rd_en_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic [NWR-1:0]      wr_en_i;
    logic [NWR*AW-1:0]   wr_addr_i;
    logic [NWR*XLEN-1:0] wr_data_i;
    logic [NWR-1:0]      alloc_en_i;
    logic [NWR*AW-1:0]   alloc_addr_i;
    logic                flush_i;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
        .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drive inputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rd_en_i = '0; rd_addr_i = '0;
        wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
        alloc_en_i = '0; alloc_addr_i = '0; flush_i = 1'b0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [63:0] d);
        wr_en_i[j] = 1'b1;
        wr_addr_i[j*AW +: AW] = AW'(a);
        wr_data_i[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_alloc(input int j, input int a);
        alloc_en_i[j] = 1'b1;
        alloc_addr_i[j*AW +: AW] = AW'(a);
    endtask

    // Drive a read and queue what it has to return.
    task automatic rd_expect(input string tag, input int p, input bit en, input int a,
                             input logic [63:0] d, input logic b);
        exp_t e;
        rd_en_i[p] = en;
        rd_addr_i[p*AW +: AW] = AW'(a);
        e.port = p; e.data = d; e.busy = b; e.tag = tag;
        q.push_back(e);
    endtask

    // Let the combinational read path settle, then drain the queue.
    task automatic check_reads();
        exp_t e;
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "_data"}, rd_data_o[e.port*XLEN +: XLEN], e.data);
            chk({e.tag, "_busy"}, {63'b0, rd_busy_o[e.port]}, {63'b0, e.busy});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Every register reads 0 and not busy after reset.
        for (int a = 0; a < NREG; a += NRD) begin
            for (int p = 0; p < NRD; p++) rd_expect("rst", p, 1'b1, a + p, 64'h0, 1'b0);
            check_reads();
        end

        // Write, readback, bypass
        tick(); clr();
        set_wr(0, 5, 64'hDEAD_BEEF_0000_0001);
        rd_expect("wr_byp", 0, 1'b1, 5, 64'hDEAD_BEEF_0000_0001, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("wr_rb", 1, 1'b1, 5, 64'hDEAD_BEEF_0000_0001, 1'b0);
        check_reads();
        set_wr(1, 5, 64'h7);
        rd_expect("byp7", 2, 1'b1, 5, 64'h7, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("rb7", 3, 1'b1, 5, 64'h7, 1'b0);
        check_reads();

        // Write collision: the higher-index port wins.
        set_wr(0, 9, 64'h11);
        set_wr(1, 9, 64'h22);
        rd_expect("coll_byp", 0, 1'b1, 9, 64'h22, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("coll_rb", 1, 1'b1, 9, 64'h22, 1'b0);
        check_reads();

        // Register 0 ignores writes and allocations.
        set_wr(0, 0, 64'hFF);
        set_alloc(1, 0);
        rd_expect("r0_same", 0, 1'b1, 0, 64'h0, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("r0_next", 0, 1'b1, 0, 64'h0, 1'b0);
        check_reads();

        // Scoreboard
        set_alloc(0, 3);
        rd_expect("alloc_same", 1, 1'b1, 3, 64'h0, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("alloc_next", 1, 1'b1, 3, 64'h0, 1'b1);
        rd_expect("rd_dis", 2, 1'b0, 3, 64'h0, 1'b0);
        check_reads();
        set_wr(1, 3, 64'h33);
        rd_expect("wr_clr_comb", 0, 1'b1, 3, 64'h33, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("wr_clr_next", 0, 1'b1, 3, 64'h33, 1'b0);
        check_reads();
        set_wr(0, 3, 64'h44);
        set_alloc(1, 3);
        rd_expect("aw_same", 3, 1'b1, 3, 64'h44, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("aw_next", 3, 1'b1, 3, 64'h44, 1'b1);
        check_reads();

        // Flush, also with alloc + write on r2 in the flush cycle
        set_alloc(0, 1);
        set_alloc(1, 2);
        tick(); clr();
        rd_expect("pre_fl1", 0, 1'b1, 1, 64'h0, 1'b1);
        rd_expect("pre_fl2", 1, 1'b1, 2, 64'h0, 1'b1);
        rd_expect("pre_fl3", 2, 1'b1, 3, 64'h44, 1'b1);
        check_reads();
        flush_i = 1'b1;
        set_alloc(0, 2);
        set_wr(1, 2, 64'h55);
        rd_expect("fl_byp", 0, 1'b1, 2, 64'h55, 1'b0);
        check_reads();
        tick(); clr();
        rd_expect("fl1", 0, 1'b1, 1, 64'h0, 1'b0);
        rd_expect("fl2", 1, 1'b1, 2, 64'h55, 1'b0);
        rd_expect("fl3", 2, 1'b1, 3, 64'h44, 1'b0);
        check_reads();

        // Asynchronous reset between edges
        set_wr(0, 4, 64'h5);
        tick(); clr();
        rd_expect("r4_pre", 0, 1'b1, 4, 64'h5, 1'b0);
        check_reads();
        #1 reset_n = 1'b0;
        rd_expect("arst_r4", 0, 1'b1, 4, 64'h0, 1'b0);
        rd_expect("arst_r9", 1, 1'b1, 9, 64'h0, 1'b0);
        check_reads();
        tick();
        reset_n = 1'b1;
        rd_expect("post_r5", 2, 1'b1, 5, 64'h0, 1'b0);
        check_reads();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
